// File: rtl/audio_pkg.sv
// ---------------------------------------------------------------------------
// audio_pkg
// Shared definitions for the audio stream reader slice.
//   - state_t      : playback sequencer states
//   - ADDR_W_DEF   : default memory word-address width
//   - DATA_W_DEF   : default sample / memory data width
// ---------------------------------------------------------------------------
package audio_pkg;

    localparam int ADDR_W_DEF = 26;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        PUSH,
        PAUSED,
        DRAIN
    } state_t;

endpackage

// File: rtl/audio_stream_reader_if.sv
// ---------------------------------------------------------------------------
// audio_stream_reader_if
// Groups the memory read handshake (req/gnt/rvalid) and the sample stream
// (valid/ready) used by the audio stream reader.
//   master : the reader side (drives mem_req/mem_addr, smp_valid/smp_data)
//   slave  : the memory + sink side (drives gnt/rvalid/rdata, smp_ready)
// ---------------------------------------------------------------------------
interface audio_stream_reader_if
    import audio_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    logic              smp_valid;
    logic [DATA_W-1:0] smp_data;
    logic              smp_ready;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata,
        output smp_valid,
        output smp_data,
        input  smp_ready
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata,
        input  smp_valid,
        input  smp_data,
        output smp_ready
    );

endinterface

// File: rtl/audio_track_table.sv
// ---------------------------------------------------------------------------
// audio_track_table
// NUM_TRACKS x {start, end} word-address register file.
//   clk, reset           : clock, synchronous active-high reset (clears all)
//   cfg_we/cfg_track     : write strobe and entry index
//   cfg_start/cfg_end    : values written (start inclusive, end exclusive)
//   rd_track             : combinational read index
//   rd_start/rd_end      : entry contents, or 0/0 for an out-of-range index
// ---------------------------------------------------------------------------
module audio_track_table
    import audio_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int NUM_TRACKS = 8,
    parameter int TRACK_W    = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [TRACK_W-1:0] cfg_track,
    input  logic [ADDR_W-1:0]  cfg_start,
    input  logic [ADDR_W-1:0]  cfg_end,
    input  logic [TRACK_W-1:0] rd_track,
    output logic [ADDR_W-1:0]  rd_start,
    output logic [ADDR_W-1:0]  rd_end
);

    // One extra bit so the bound compare works even when 2^TRACK_W == NUM_TRACKS.
    localparam logic [TRACK_W:0] NUM_TRACKS_EXT = (TRACK_W + 1)'(NUM_TRACKS);

    logic [ADDR_W-1:0] start_mem [NUM_TRACKS];
    logic [ADDR_W-1:0] end_mem   [NUM_TRACKS];

    logic wr_in_range;
    logic rd_in_range;

    assign wr_in_range = ({1'b0, cfg_track} < NUM_TRACKS_EXT);
    assign rd_in_range = ({1'b0, rd_track}  < NUM_TRACKS_EXT);

    // Entry storage: reset leaves every track empty (start = end = 0), so an
    // unconfigured track plays as "done immediately". Writes to indices past
    // the table are dropped rather than aliased onto a real entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_TRACKS; i++) begin
                start_mem[i] <= '0;
                end_mem[i]   <= '0;
            end
        end else if (cfg_we && wr_in_range) begin
            start_mem[cfg_track] <= cfg_start;
            end_mem[cfg_track]   <= cfg_end;
        end
    end

    // Read port: an out-of-range track looks like an empty entry.
    always_comb begin
        rd_start = '0;
        rd_end   = '0;
        if (rd_in_range) begin
            rd_start = start_mem[rd_track];
            rd_end   = end_mem[rd_track];
        end
    end

endmodule

// File: rtl/audio_stream_reader.sv
// ---------------------------------------------------------------------------
// audio_stream_reader
// Plays tracks out of word-addressed memory: one read at a time through a
// req/gnt/rvalid handshake, each word forwarded to a valid/ready sample sink.
// Supports pause/resume, stop (draining any read in flight), loop mode and a
// one-cycle end-of-track pulse.
//   clk, reset             : clock, synchronous active-high reset
//   cfg_we/cfg_track/
//   cfg_start/cfg_end      : track table write port
//   cmd_play/pause/stop    : commands (stop > pause > play)
//   sel_track              : track picked by cmd_play from IDLE
//   loop_en                : sampled at end of track, 1 restarts the track
//   bus (master)           : mem_req/mem_addr/mem_gnt/mem_rvalid/mem_rdata,
//                            smp_valid/smp_data/smp_ready
//   busy/paused            : state != IDLE / state == PAUSED
//   track_done             : one-cycle end-of-track pulse
//   cur_track              : track latched by the last play from IDLE
// ---------------------------------------------------------------------------
module audio_stream_reader
    import audio_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int NUM_TRACKS = 8,
    parameter int TRACK_W    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_we,
    input  logic [TRACK_W-1:0]    cfg_track,
    input  logic [ADDR_W-1:0]     cfg_start,
    input  logic [ADDR_W-1:0]     cfg_end,
    input  logic                  cmd_play,
    input  logic                  cmd_pause,
    input  logic                  cmd_stop,
    input  logic [TRACK_W-1:0]    sel_track,
    input  logic                  loop_en,
    audio_stream_reader_if.master bus,
    output logic                  busy,
    output logic                  paused,
    output logic                  track_done,
    output logic [TRACK_W-1:0]    cur_track
);

    state_t             state, state_n;
    logic [ADDR_W-1:0]  addr, addr_n;
    logic [ADDR_W-1:0]  start_r, start_n;
    logic [ADDR_W-1:0]  end_r, end_n;
    logic [TRACK_W-1:0] track_r, track_n;
    logic [DATA_W-1:0]  smp_r, smp_n;
    logic               pause_pending, pause_pending_n;
    logic               done_r, done_n;

    logic [ADDR_W-1:0]  tbl_start;
    logic [ADDR_W-1:0]  tbl_end;
    logic [ADDR_W-1:0]  addr_inc;
    logic               at_end;

    audio_track_table #(
        .ADDR_W     (ADDR_W),
        .NUM_TRACKS (NUM_TRACKS),
        .TRACK_W    (TRACK_W)
    ) u_table (
        .clk       (clk),
        .reset     (reset),
        .cfg_we    (cfg_we),
        .cfg_track (cfg_track),
        .cfg_start (cfg_start),
        .cfg_end   (cfg_end),
        .rd_track  (sel_track),
        .rd_start  (tbl_start),
        .rd_end    (tbl_end)
    );

    assign addr_inc = addr + ADDR_W'(1);
    assign at_end   = (addr_inc == end_r);

    // State and working registers. start/end are private copies taken at
    // play time, so table rewrites never disturb a track already playing.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            addr          <= '0;
            start_r       <= '0;
            end_r         <= '0;
            track_r       <= '0;
            smp_r         <= '0;
            pause_pending <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state         <= state_n;
            addr          <= addr_n;
            start_r       <= start_n;
            end_r         <= end_n;
            track_r       <= track_n;
            smp_r         <= smp_n;
            pause_pending <= pause_pending_n;
            done_r        <= done_n;
        end
    end

    // Next-state logic. A read that has been granted is always seen through
    // to its rvalid (WAIT or DRAIN), so pause/stop arriving together with gnt
    // are folded into the post-grant handling instead of abandoning the read.
    always_comb begin
        state_n         = state;
        addr_n          = addr;
        start_n         = start_r;
        end_n           = end_r;
        track_n         = track_r;
        smp_n           = smp_r;
        pause_pending_n = pause_pending;
        done_n          = 1'b0;

        case (state)
            IDLE: begin
                if (cmd_play && !cmd_stop && !cmd_pause) begin
                    track_n = sel_track;
                    start_n = tbl_start;
                    end_n   = tbl_end;
                    addr_n  = tbl_start;
                    if (tbl_start >= tbl_end) begin
                        done_n = 1'b1;
                    end else begin
                        state_n = REQ;
                    end
                end
            end

            REQ: begin
                if (bus.mem_gnt) begin
                    if (cmd_stop) begin
                        state_n = DRAIN;
                    end else begin
                        state_n = WAIT;
                        if (cmd_pause) begin
                            pause_pending_n = 1'b1;
                        end
                    end
                end else if (cmd_stop) begin
                    state_n = IDLE;
                end else if (cmd_pause) begin
                    state_n = PAUSED;
                end
            end

            WAIT: begin
                if (cmd_stop) begin
                    pause_pending_n = 1'b0;
                    state_n         = bus.mem_rvalid ? IDLE : DRAIN;
                end else begin
                    if (cmd_pause) begin
                        pause_pending_n = 1'b1;
                    end
                    if (bus.mem_rvalid) begin
                        smp_n   = bus.mem_rdata;
                        state_n = PUSH;
                    end
                end
            end

            DRAIN: begin
                if (bus.mem_rvalid) begin
                    state_n = IDLE;
                end
            end

            // End of track wins over a pending pause; the pending flag is
            // dropped either way once the sample leaves.
            PUSH: begin
                if (cmd_stop) begin
                    pause_pending_n = 1'b0;
                    state_n         = IDLE;
                end else if (bus.smp_ready) begin
                    addr_n          = addr_inc;
                    pause_pending_n = 1'b0;
                    if (at_end) begin
                        if (loop_en) begin
                            addr_n  = start_r;
                            state_n = REQ;
                        end else begin
                            done_n  = 1'b1;
                            state_n = IDLE;
                        end
                    end else if (pause_pending || cmd_pause) begin
                        state_n = PAUSED;
                    end else begin
                        state_n = REQ;
                    end
                end else if (cmd_pause) begin
                    pause_pending_n = 1'b1;
                end
            end

            PAUSED: begin
                if (cmd_stop) begin
                    state_n = IDLE;
                end else if (cmd_play && !cmd_pause) begin
                    state_n = REQ;
                end
            end

            default: begin
                state_n         = IDLE;
                pause_pending_n = 1'b0;
            end
        endcase
    end

    assign bus.mem_req   = (state == REQ);
    assign bus.mem_addr  = addr;
    assign bus.smp_valid = (state == PUSH);
    assign bus.smp_data  = smp_r;

    assign busy       = (state != IDLE);
    assign paused     = (state == PAUSED);
    assign track_done = done_r;
    assign cur_track  = track_r;

endmodule
